// File: rtl/io_cycle_ctrl.sv
// io_cycle_ctrl: CPU-side sequencer running T1/T2/TW/T3 I/O machine cycles into the port block.
// Optional wait-state timeout is enabled by defining IO_TIMEOUT_EN.
module io_cycle_ctrl #(
  parameter int                ADDR_W    = 4,
  parameter int                DATA_W    = 8,
  parameter int                NUM_PORTS = 3,
  parameter logic [ADDR_W-1:0] IDLE_ADDR = 4'hF,
  parameter logic [DATA_W-1:0] FILL      = 8'hFF,
  parameter int                WAIT_MAX  = 15
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Req_Valid,
  output logic              Req_Ready,
  input  logic              Req_Wr,
  input  logic [ADDR_W-1:0] Req_Port,
  input  logic [DATA_W-1:0] Req_Data,
  output logic              Rsp_Valid,
  output logic [DATA_W-1:0] Rsp_Data,
  output logic              Rsp_Err,
  output logic [ADDR_W-1:0] Io_Addr,
  output logic [DATA_W-1:0] Io_D_In,
  output logic              Io_Wr,
  output logic              Io_Rd,
  input  logic [DATA_W-1:0] Io_D_Out,
  input  logic              Io_Ready
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_T1   = 3'd1;
  localparam logic [2:0] S_T2   = 3'd2;
  localparam logic [2:0] S_TW   = 3'd3;
  localparam logic [2:0] S_T3   = 3'd4;

  logic [2:0]        state_r;
  logic [2:0]        state_s;
  logic              ready_r;
  logic              wr_r;
  logic [ADDR_W-1:0] port_r;
  logic [DATA_W-1:0] data_r;
  logic [DATA_W-1:0] rsp_data_r;
  logic              rsp_err_r;
  logic              accept_s;
  logic              strobe_s;
  logic              capture_s;
  logic              timeout_s;

  assign accept_s  = Req_Valid & ready_r;
  assign strobe_s  = (state_r == S_T2) || (state_r == S_TW);
  assign capture_s = strobe_s & Io_Ready;

`ifdef IO_TIMEOUT_EN
  localparam int CNT_W = $clog2(WAIT_MAX + 1);
  logic [CNT_W-1:0] wait_cnt_r;

  // TW cycle counter; restarts at the top of every machine cycle
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wait_cnt_r <= '0;
    end else if (state_r == S_T1) begin
      wait_cnt_r <= '0;
    end else if (state_r == S_TW) begin
      wait_cnt_r <= wait_cnt_r + 1'b1;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  assign timeout_s = (state_r == S_TW) && !Io_Ready && (wait_cnt_r == CNT_W'(WAIT_MAX - 1));
`else
  logic unused_wait_max;
  assign unused_wait_max = (WAIT_MAX != 0);
  assign timeout_s       = 1'b0;
`endif

  // Next-state logic for the machine cycle sequence
  always_comb begin
    state_s = S_IDLE;
    case (state_r)
      S_IDLE:  state_s = accept_s ? S_T1 : S_IDLE;
      S_T1:    state_s = S_T2;
      S_T2:    state_s = Io_Ready ? S_T3 : S_TW;
      S_TW:    state_s = (Io_Ready || timeout_s) ? S_T3 : S_TW;
      S_T3:    state_s = accept_s ? S_T1 : S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // State, request latch and response registers
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_r    <= S_IDLE;
      ready_r    <= 1'b0;
      wr_r       <= 1'b0;
      port_r     <= '0;
      data_r     <= '0;
      rsp_data_r <= '0;
      rsp_err_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      // Ready is registered from the next state so it stays low during reset
      ready_r <= (state_s == S_IDLE) || (state_s == S_T3);
      if (accept_s) begin
        wr_r   <= Req_Wr;
        port_r <= Req_Port;
        data_r <= Req_Data;
      end
      if (capture_s) begin
        rsp_err_r <= 1'b0;
        if (wr_r) begin
          rsp_data_r <= '0;
        end else if (int'(port_r) < NUM_PORTS) begin
          rsp_data_r <= Io_D_Out;
        end else begin
          rsp_data_r <= FILL;
        end
      end else if (timeout_s) begin
        rsp_err_r  <= 1'b1;
        rsp_data_r <= FILL;
      end
    end
  end

  assign Req_Ready = ready_r;
  assign Rsp_Valid = (state_r == S_T3);
  assign Rsp_Data  = rsp_data_r;
  assign Rsp_Err   = rsp_err_r;
  assign Io_Addr   = (state_r == S_IDLE) ? IDLE_ADDR : port_r;
  assign Io_D_In   = ((state_r != S_IDLE) && wr_r) ? data_r : '0;
  assign Io_Wr     = strobe_s & wr_r;
  assign Io_Rd     = strobe_s & ~wr_r;

endmodule

// File: tb/tb_io_cycle_ctrl.sv
// Self-checking bench for io_cycle_ctrl: directed scenarios plus randomized transactions
// checked against a per-transaction timing model (IO_TIMEOUT_EN selects timeout expectations).
module tb_io_cycle_ctrl;
  logic       Clk = 1'b0;
  logic       Rst;
  logic       Req_Valid, Req_Ready, Req_Wr;
  logic [3:0] Req_Port;
  logic [7:0] Req_Data;
  logic       Rsp_Valid, Rsp_Err;
  logic [7:0] Rsp_Data;
  logic [3:0] Io_Addr;
  logic [7:0] Io_D_In, Io_D_Out;
  logic       Io_Wr, Io_Rd, Io_Ready;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int rsp_cyc = 0;
  logic [7:0] last_rsp = 8'h00;

  io_cycle_ctrl #(.WAIT_MAX(4)) dut (
    .Clk(Clk), .Rst(Rst), .Req_Valid(Req_Valid), .Req_Ready(Req_Ready), .Req_Wr(Req_Wr),
    .Req_Port(Req_Port), .Req_Data(Req_Data), .Rsp_Valid(Rsp_Valid), .Rsp_Data(Rsp_Data),
    .Rsp_Err(Rsp_Err), .Io_Addr(Io_Addr), .Io_D_In(Io_D_In), .Io_Wr(Io_Wr), .Io_Rd(Io_Rd),
    .Io_D_Out(Io_D_Out), .Io_Ready(Io_Ready)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // One full transaction: expected bus behaviour derived from wait count and request fields
  task automatic do_txn(input logic wr, input logic [3:0] port, input logic [7:0] data,
                        input int nwait, input bit fix_dout, input logic [7:0] dout);
    logic [7:0] exp_rsp;
    logic [13:0] exp_bus, got_bus;
    bit strobe, last;
    exp_rsp = 8'h00;
    Req_Valid = 1'b1; Req_Wr = wr; Req_Port = port; Req_Data = data;
    vectors++;
    if (Req_Ready !== 1'b1) begin
      miscompares++;
      $display("FAIL txn_entry_ready: got %b want 1", Req_Ready);
    end
    for (int c = 1; c <= 3 + nwait; c++) begin
      @(posedge Clk); #1;
      Req_Valid = 1'b0; Req_Wr = 1'($urandom); Req_Port = 4'($urandom); Req_Data = 8'($urandom);
      strobe  = (c >= 2) && (c <= 2 + nwait);
      last    = (c == 3 + nwait);
      exp_bus = {port, wr & strobe, !wr & strobe, wr ? data : 8'h00};
      got_bus = {Io_Addr, Io_Wr, Io_Rd, Io_D_In};
      vectors++;
      if (got_bus !== exp_bus || Rsp_Valid !== last || Req_Ready !== last) begin
        miscompares++;
        $display("FAIL txn_bus c=%0d: got bus=%h vld=%b rdy=%b want bus=%h vld=%b rdy=%b",
                 c, got_bus, Rsp_Valid, Req_Ready, exp_bus, last, last);
      end
      if (last) begin
        vectors++;
        if (Rsp_Data !== exp_rsp || Rsp_Err !== 1'b0) begin
          miscompares++;
          $display("FAIL txn_rsp: got data=%h err=%b want data=%h err=0", Rsp_Data, Rsp_Err, exp_rsp);
        end
        rsp_cyc  = cyc;
        last_rsp = exp_rsp;
      end
      Io_D_Out = (fix_dout && c == 2 + nwait) ? dout : 8'($urandom);
      if (c >= 2 && c <= 1 + nwait) Io_Ready = 1'b0;
      else if (c == 2 + nwait)      Io_Ready = 1'b1;
      else                          Io_Ready = 1'($urandom);
      if (c == 2 + nwait) exp_rsp = wr ? 8'h00 : ((port < 4'd3) ? Io_D_Out : 8'hFF);
    end
  endtask

  task automatic idle_cycles(input int n);
    Req_Valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge Clk); #1;
      Io_Ready = 1'($urandom);
      vectors++;
      if (Io_Addr !== 4'hF || Io_Wr !== 1'b0 || Io_Rd !== 1'b0 || Io_D_In !== 8'h00 ||
          Rsp_Valid !== 1'b0 || Req_Ready !== 1'b1 || Rsp_Data !== last_rsp) begin
        miscompares++;
        $display("FAIL idle: got addr=%h wr=%b rd=%b din=%h vld=%b rdy=%b data=%h want F/0/0/00/0/1/%h",
                 Io_Addr, Io_Wr, Io_Rd, Io_D_In, Rsp_Valid, Req_Ready, Rsp_Data, last_rsp);
      end
    end
  endtask

  task automatic apply_reset();
    Rst = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    vectors++;
    if (Req_Ready !== 1'b0 || Rsp_Valid !== 1'b0 || Rsp_Data !== 8'h00 || Rsp_Err !== 1'b0 ||
        Io_Addr !== 4'hF || Io_D_In !== 8'h00 || Io_Wr !== 1'b0 || Io_Rd !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_values: got rdy=%b vld=%b data=%h err=%b addr=%h din=%h wr=%b rd=%b want 0/0/00/0/F/00/0/0",
               Req_Ready, Rsp_Valid, Rsp_Data, Rsp_Err, Io_Addr, Io_D_In, Io_Wr, Io_Rd);
    end
    #3 Rst = 1'b0;
    @(posedge Clk); #1;
    vectors++;
    if (Req_Ready !== 1'b1 || Rsp_Valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: got rdy=%b vld=%b want 1/0", Req_Ready, Rsp_Valid);
    end
    last_rsp = 8'h00;
  endtask

  task automatic test_reset();
    Req_Valid = 1'b0; Req_Wr = 1'b0; Req_Port = 4'h0; Req_Data = 8'h00;
    Io_D_Out = 8'h00; Io_Ready = 1'b1;
    apply_reset();
  endtask

  task automatic test_reset_in_tw();
    Req_Valid = 1'b1; Req_Wr = 1'b0; Req_Port = 4'h0;
    @(posedge Clk); #1; Req_Valid = 1'b0; Io_Ready = 1'b0;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    vectors++;
    if (Io_Rd !== 1'b1) begin
      miscompares++;
      $display("FAIL tw_rd_before_reset: got %b want 1", Io_Rd);
    end
    #2 Rst = 1'b1;
    #1;
    vectors++;
    if (Io_Rd !== 1'b0 || Io_Addr !== 4'hF || Rsp_Valid !== 1'b0 || Req_Ready !== 1'b0) begin
      miscompares++;
      $display("FAIL tw_async_reset: got rd=%b addr=%h vld=%b rdy=%b want 0/F/0/0",
               Io_Rd, Io_Addr, Rsp_Valid, Req_Ready);
    end
    Io_Ready = 1'b1;
    apply_reset();
  endtask

  task automatic test_out();
    do_txn(1'b1, 4'h1, 8'hA5, 0, 1'b0, 8'h00);
    idle_cycles(1);
  endtask

  task automatic test_in_wait();
    do_txn(1'b0, 4'h0, 8'h00, 2, 1'b1, 8'h3C);
    idle_cycles(1);
  endtask

  task automatic test_back_to_back();
    int first;
    do_txn(1'b1, 4'h2, 8'h5A, 0, 1'b0, 8'h00);
    first = rsp_cyc;
    do_txn(1'b0, 4'h2, 8'h00, 0, 1'b1, 8'h5A);
    vectors++;
    if (rsp_cyc - first != 3) begin
      miscompares++;
      $display("FAIL b2b_spacing: got %0d cycles want 3", rsp_cyc - first);
    end
    idle_cycles(1);
  endtask

  task automatic test_undecoded();
    do_txn(1'b0, 4'h7, 8'h00, 1, 1'b0, 8'h00);
    idle_cycles(1);
  endtask

  task automatic test_timeout();
    bit seen_rsp;
    seen_rsp = 1'b0;
    Req_Valid = 1'b1; Req_Wr = 1'b0; Req_Port = 4'h1;
    @(posedge Clk); #1; Req_Valid = 1'b0; Io_Ready = 1'b0;
`ifdef IO_TIMEOUT_EN
    for (int c = 2; c <= 8 && !seen_rsp; c++) begin
      @(posedge Clk); #1;
      vectors++;
      if (Io_Rd !== (c <= 6) || Rsp_Valid !== (c == 7)) begin
        miscompares++;
        $display("FAIL timeout_seq c=%0d: got rd=%b vld=%b want %b/%b", c, Io_Rd, Rsp_Valid, c <= 6, c == 7);
      end
      if (Rsp_Valid === 1'b1) begin
        seen_rsp = 1'b1;
        vectors++;
        if (Rsp_Err !== 1'b1 || Rsp_Data !== 8'hFF) begin
          miscompares++;
          $display("FAIL timeout_rsp: got err=%b data=%h want 1/FF", Rsp_Err, Rsp_Data);
        end
      end
    end
    vectors++;
    if (!seen_rsp) begin
      miscompares++;
      $display("FAIL timeout_no_rsp: got no Rsp_Valid want one");
    end
`else
    for (int c = 2; c <= 101; c++) begin
      @(posedge Clk); #1;
      vectors++;
      if (Io_Rd !== 1'b1 || Rsp_Valid !== 1'b0) begin
        miscompares++;
        $display("FAIL tw_hold c=%0d: got rd=%b vld=%b want 1/0", c, Io_Rd, Rsp_Valid);
      end
    end
`endif
    Io_Ready = 1'b1;
    apply_reset();
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      do_txn(1'($urandom), 4'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'b0, 8'h00);
      if ($urandom_range(0, 1) == 0) idle_cycles(int'($urandom_range(1, 3)));
    end
    idle_cycles(1);
  endtask

  initial begin
    test_reset();
    test_reset_in_tw();
    test_out();
    test_in_wait();
    test_back_to_back();
    test_undecoded();
    test_timeout();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
